// File: rtl/sweep_controller.sv
// Single-axis sweep sequencer: home CW, sweep CCW tracking the brightest ADC
// sample, then seek back to it. Define SWEEP_TIMEOUT_EN for the per-state watchdog.
module sweep_controller #(
  parameter logic [31:0] PW_MIN  = 32'd1000,
  parameter logic [31:0] PW_MAX  = 32'd25000,
  parameter int          ADC_W   = 12
`ifdef SWEEP_TIMEOUT_EN
  , parameter logic [31:0] TIMEOUT = 32'd50000000
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [ADC_W-1:0] adc_value,
  input  logic             adc_valid,
  input  logic [31:0]      servo_position,
  input  logic             PWM_limit,
  output logic             BTN_0,
  output logic             BTN_1,
  output logic             MC,
  output logic             ES,
  output logic [31:0]      pulseWidth_max,
  output logic [ADC_W-1:0] max_value,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // state    | meaning
  // ST_IDLE  | waiting for start, servo released
  // ST_HOME  | driving CW until servo_position <= PW_MIN
  // ST_SWEEP | driving CCW, capturing brightest sample and its pulse width
  // ST_SEEK  | driving CW back to pulseWidth_max
  typedef enum logic [1:0] {ST_IDLE, ST_HOME, ST_SWEEP, ST_SEEK} state_t;

  state_t           state, state_nxt;
  logic             btn0_nxt, btn1_nxt, mc_nxt, es_nxt, busy_nxt, done_nxt;
  logic [31:0]      pw_nxt;
  logic [ADC_W-1:0] max_nxt;
  logic             new_max;
  logic             sweep_end;
  logic             tmo_hit;

`ifdef SWEEP_TIMEOUT_EN
  logic [31:0] tmr;
  logic        error_q;

  assign tmo_hit = (state != ST_IDLE) && (tmr == 32'd0);
  assign error   = error_q;

  // Reloaded on every state change so each motion state gets the full budget.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tmr     <= '0;
      error_q <= 1'b0;
    end else begin
      if (tmo_hit)
        error_q <= 1'b1;
      if (state_nxt != state)
        tmr <= TIMEOUT - 32'd1;
      else if (tmr != 32'd0)
        tmr <= tmr - 32'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign error   = 1'b0;
`endif

  assign new_max   = (state == ST_SWEEP) && adc_valid && (adc_value > max_value);
  assign sweep_end = PWM_limit || (servo_position >= PW_MAX);

  always_comb begin
    state_nxt = state;
    btn0_nxt  = 1'b0;
    btn1_nxt  = 1'b0;
    mc_nxt    = 1'b0;
    es_nxt    = 1'b0;
    done_nxt  = 1'b0;
    busy_nxt  = 1'b1;
    pw_nxt    = pulseWidth_max;
    max_nxt   = max_value;

    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = ST_HOME;
          busy_nxt  = 1'b1;
          btn1_nxt  = 1'b1;
          max_nxt   = '0;
          pw_nxt    = PW_MIN;
        end
      end
      ST_HOME: begin
        if (servo_position <= PW_MIN) begin
          state_nxt = ST_SWEEP;
          btn0_nxt  = 1'b1;
          es_nxt    = 1'b1;
        end else begin
          btn1_nxt = 1'b1;
        end
      end
      ST_SWEEP: begin
        // A sample arriving in the final sweep cycle still counts.
        if (new_max) begin
          max_nxt = adc_value;
          pw_nxt  = servo_position;
          mc_nxt  = 1'b1;
        end
        if (sweep_end) begin
          state_nxt = ST_SEEK;
          btn1_nxt  = servo_position > pw_nxt;
        end else begin
          btn0_nxt = 1'b1;
          es_nxt   = 1'b1;
        end
      end
      ST_SEEK: begin
        if (servo_position <= pulseWidth_max) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          btn1_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    if (tmo_hit) begin
      state_nxt = ST_IDLE;
      btn0_nxt  = 1'b0;
      btn1_nxt  = 1'b0;
      es_nxt    = 1'b0;
      done_nxt  = 1'b0;
      busy_nxt  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= ST_IDLE;
      BTN_0          <= 1'b0;
      BTN_1          <= 1'b0;
      MC             <= 1'b0;
      ES             <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pulseWidth_max <= PW_MIN;
      max_value      <= '0;
    end else begin
      state          <= state_nxt;
      BTN_0          <= btn0_nxt;
      BTN_1          <= btn1_nxt;
      MC             <= mc_nxt;
      ES             <= es_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pulseWidth_max <= pw_nxt;
      max_value      <= max_nxt;
    end
  end

endmodule

// File: tb/tb_sweep_controller.sv
// Bench for sweep_controller: reset checks, a vector table, hand-written corner
// sequences, and randomized sweeps checked against a max-tracking model.
module tb_sweep_controller;

  localparam logic [31:0] PW_MIN = 32'd1000;
  localparam logic [31:0] PW_MAX = 32'd25000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [11:0] adc_value;
  logic        adc_valid;
  logic [31:0] servo_position;
  logic        PWM_limit;
  logic        BTN_0, BTN_1, MC, ES, busy, done, error;
  logic [31:0] pulseWidth_max;
  logic [11:0] max_value;

  always #5 CLK = ~CLK;

`ifdef SWEEP_TIMEOUT_EN
  sweep_controller #(.TIMEOUT(32'd100)) dut (
`else
  sweep_controller dut (
`endif
    .CLK(CLK), .RST(RST), .start(start), .adc_value(adc_value), .adc_valid(adc_valid),
    .servo_position(servo_position), .PWM_limit(PWM_limit), .BTN_0(BTN_0), .BTN_1(BTN_1),
    .MC(MC), .ES(ES), .pulseWidth_max(pulseWidth_max), .max_value(max_value),
    .busy(busy), .done(done), .error(error));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // flags = {busy, BTN_0, BTN_1, ES, MC, done}
  typedef struct {
    logic        st;
    logic [31:0] pos;
    logic        av;
    logic [11:0] adc;
    logic        lim;
    logic [5:0]  flags;
    logic [11:0] emax;
    logic [31:0] epw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input int pos, input logic av, input int adc,
                              input logic lim, input logic [5:0] flags, input int emax,
                              input int epw);
    vec_t v;
    v.st = st; v.pos = 32'(pos); v.av = av; v.adc = 12'(adc); v.lim = lim;
    v.flags = flags; v.emax = 12'(emax); v.epw = 32'(epw);
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0, h, step;
    logic [11:0] exp_max;
    logic [31:0] exp_pw;
    logic        exp_mc, exp_done, use_lim, sweep_end;
    int          lim_at;

    RST = 1'b1; start = 1'b1; adc_valid = 1'b0; adc_value = '0;
    servo_position = 32'd1500; PWM_limit = 1'b0;
    tick();
    tick();
    chk("reset_state", {busy, BTN_0, BTN_1, ES, MC, done, error, max_value, pulseWidth_max},
        {7'b0, 12'd0, PW_MIN});
    RST = 1'b0; start = 1'b0;
    tick();
    chk("start_in_reset_ignored", {busy, BTN_1}, 2'b00);

    //        st  pos    av adc   lim flags      max  pw
    tbl.push_back(mk(1, 1500,  0, 0,    0, 6'b101000, 0,   1000));
    tbl.push_back(mk(0, 1500,  1, 4000, 0, 6'b101000, 0,   1000));
    tbl.push_back(mk(0, 1000,  0, 0,    0, 6'b110100, 0,   1000));
    tbl.push_back(mk(0, 5000,  1, 100,  0, 6'b110110, 100, 5000));
    tbl.push_back(mk(1, 8000,  0, 0,    0, 6'b110100, 100, 5000));
    tbl.push_back(mk(0, 12000, 1, 900,  0, 6'b110110, 900, 12000));
    tbl.push_back(mk(0, 15000, 1, 900,  0, 6'b110100, 900, 12000));
    tbl.push_back(mk(0, 20000, 1, 300,  0, 6'b110100, 900, 12000));
    tbl.push_back(mk(0, 24999, 0, 0,    0, 6'b110100, 900, 12000));
    tbl.push_back(mk(0, 25000, 0, 0,    0, 6'b101000, 900, 12000));
    tbl.push_back(mk(0, 18000, 0, 0,    0, 6'b101000, 900, 12000));
    tbl.push_back(mk(0, 12000, 0, 0,    0, 6'b000001, 900, 12000));
    tbl.push_back(mk(0, 12000, 1, 50,   0, 6'b000000, 900, 12000));
    tbl.push_back(mk(1, 900,   0, 0,    0, 6'b101000, 0,   1000));
    tbl.push_back(mk(0, 900,   0, 0,    0, 6'b110100, 0,   1000));
    tbl.push_back(mk(0, 3000,  1, 200,  0, 6'b110110, 200, 3000));
    tbl.push_back(mk(0, 18000, 1, 700,  1, 6'b100010, 700, 18000));
    tbl.push_back(mk(0, 18000, 0, 0,    0, 6'b000001, 700, 18000));
    tbl.push_back(mk(0, 18000, 0, 0,    1, 6'b000000, 700, 18000));

    foreach (tbl[i]) begin
      start = tbl[i].st; servo_position = tbl[i].pos; adc_valid = tbl[i].av;
      adc_value = tbl[i].adc; PWM_limit = tbl[i].lim;
      tick();
      chk($sformatf("vec%0d", i), {busy, BTN_0, BTN_1, ES, MC, done, max_value, pulseWidth_max},
          {tbl[i].flags, tbl[i].emax, tbl[i].epw});
    end
    start = 1'b0; adc_valid = 1'b0; PWM_limit = 1'b0;

    // Reset in the middle of SEEK aborts immediately
    servo_position = 32'd1000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    servo_position = 32'd6000; adc_valid = 1'b1; adc_value = 12'd50;
    tick();
    adc_valid = 1'b0; servo_position = 32'd25000;
    tick();
    chk("seek_before_rst", {busy, BTN_1, pulseWidth_max}, {2'b11, 32'd6000});
    RST = 1'b1;
    tick();
    chk("rst_mid_seek", {busy, BTN_0, BTN_1, ES, done, max_value, pulseWidth_max},
        {5'b0, 12'd0, PW_MIN});
    RST = 1'b0;
    tick();

    for (int it = 0; it < 20; it++) begin
      p0 = $urandom_range(3000, 1001);
      servo_position = 32'(p0); start = 1'b1;
      tick();
      start = 1'b0;
      chk("rnd_start_latency", {busy, BTN_0, BTN_1}, 3'b101);
      h = $urandom_range(3, 0);
      for (int k = 0; k < h; k++) begin
        adc_valid = 1'($urandom_range(1, 0)); adc_value = 12'($urandom_range(4095, 0));
        tick();
        chk("rnd_home", {busy, BTN_0, BTN_1, ES}, 4'b1010);
      end
      adc_valid = 1'b0;
      servo_position = 32'($urandom_range(1000, 800));
      tick();
      chk("rnd_sweep_entry", {busy, BTN_0, BTN_1, ES, max_value, pulseWidth_max},
          {4'b1101, 12'd0, PW_MIN});

      exp_max = '0; exp_pw = PW_MIN;
      use_lim = ($urandom_range(3, 0) == 0);
      lim_at  = $urandom_range(20000, 4000);
      sweep_end = 1'b0;
      for (int k = 0; k < 200 && !sweep_end; k++) begin
        servo_position = servo_position + 32'($urandom_range(1500, 400));
        adc_valid = 1'($urandom_range(1, 0));
        adc_value = 12'($urandom_range(20, 0) * 200);
        start     = ($urandom_range(9, 0) == 0);
        PWM_limit = use_lim && (servo_position >= 32'(lim_at));
        sweep_end = PWM_limit || (servo_position >= PW_MAX);
        exp_mc = adc_valid && (adc_value > exp_max);
        if (exp_mc) begin
          exp_max = adc_value;
          exp_pw  = servo_position;
        end
        tick();
        start = 1'b0;
        chk("rnd_sweep", {BTN_0, BTN_1, ES, MC, busy, max_value, pulseWidth_max},
            {sweep_end ? {1'b0, servo_position > exp_pw, 1'b0} : 3'b101,
             exp_mc, 1'b1, exp_max, exp_pw});
      end
      adc_valid = 1'b0; PWM_limit = 1'b0;
      chk("rnd_sweep_ended", {31'd0, sweep_end}, 32'd1);

      exp_done = 1'b0;
      for (int k = 0; k < 100 && !exp_done; k++) begin
        step = $urandom_range(2000, 500);
        servo_position = (servo_position > 32'(step)) ? servo_position - 32'(step) : 32'd0;
        exp_done = (servo_position <= exp_pw);
        tick();
        chk("rnd_seek", {busy, BTN_0, BTN_1, done, BTN_0 & BTN_1},
            {!exp_done, 1'b0, !exp_done, exp_done, 1'b0});
      end
      chk("rnd_seek_ended", {31'd0, exp_done}, 32'd1);
      tick();
      chk("rnd_done_pulse", {busy, done, max_value, pulseWidth_max}, {2'b00, exp_max, exp_pw});
    end

`ifdef SWEEP_TIMEOUT_EN
    servo_position = 32'd5000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    chk("timeout_not_yet", {busy, BTN_1, error}, 3'b110);
    tick();
    chk("timeout_hit", {busy, BTN_0, BTN_1, ES, done, error}, 6'b000001);
    repeat (3) tick();
    chk("timeout_sticky", {busy, error}, 2'b01);
`else
    chk("error_tied_low", {63'd0, error}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
